// File: rtl/nnrv_pkg.sv
// Shared nnrv definitions: response-owner encoding and default bus widths.
// The optional starvation override (NNRV_ARB_STARVE_EN) uses CNT_W here.
package nnrv_pkg;

  localparam int XLEN_DEF       = 32;
  localparam int ADDR_WIDTH_DEF = 8;
  localparam int CNT_W          = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_MEM  = 2'd2
  } owner_e;

  // Who owns the read data coming back next cycle; stores and flushed fetches own nothing.
  function automatic owner_e next_owner(input logic if_gnt, input logic if_flush,
                                        input logic mem_gnt, input logic mem_we);
    owner_e own;
    own = OWN_NONE;
    if (if_gnt && !if_flush) begin
      own = OWN_IF;
    end else if (mem_gnt && !mem_we) begin
      own = OWN_MEM;
    end
    return own;
  endfunction

endpackage

// File: rtl/nnrv_ram_arb_if.sv
// Bundle of requester, response and RAM-side signals around nnrv_ram_arb.
// Handshake: a requester holds req/addr/mask/wdata stable until gnt; gnt is the accept,
// stores complete at gnt, reads return rvalid exactly one cycle after gnt.
interface nnrv_ram_arb_if import nnrv_pkg::*; #(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int XLEN       = XLEN_DEF
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic [3:0]            if_mask;
  logic                  if_flush;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [XLEN-1:0]       if_rdata;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [3:0]            mem_mask;
  logic [XLEN-1:0]       mem_wdata;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [XLEN-1:0]       mem_rdata;

  logic                  ram_en;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [3:0]            ram_mask;
  logic [XLEN-1:0]       ram_wdata;
  logic [XLEN-1:0]       ram_rdata;

  // Requesters and the RAM macro, seen from outside the arbiter.
  modport master (
    output if_req, if_addr, if_mask, if_flush,
    output mem_req, mem_we, mem_addr, mem_mask, mem_wdata,
    output ram_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    input  ram_en, ram_we, ram_addr, ram_mask, ram_wdata
  );

  modport slave (
    input  if_req, if_addr, if_mask, if_flush,
    input  mem_req, mem_we, mem_addr, mem_mask, mem_wdata,
    input  ram_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    output ram_en, ram_we, ram_addr, ram_mask, ram_wdata
  );

endinterface

// File: rtl/nnrv_arb_prio.sv
// Two-way combinational priority picker: mem beats fetch unless fetch has been starved to the limit.
module nnrv_arb_prio (
  input  logic i_if_req,
  input  logic i_mem_req,
  input  logic i_at_limit,
  output logic o_if_gnt,
  output logic o_mem_gnt
);

  logic w_if_override;

  assign w_if_override = i_if_req & i_at_limit;
  assign o_mem_gnt     = i_mem_req & ~w_if_override;
  assign o_if_gnt      = i_if_req & (~i_mem_req | i_at_limit);

endmodule

// File: rtl/nnrv_ram_arb.sv
// Single-port RAM arbiter between fetch and load/store; read data returns one cycle after grant.
// Build with NNRV_ARB_STARVE_EN to enable the fetch starvation override.
module nnrv_ram_arb import nnrv_pkg::*; #(
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int XLEN         = XLEN_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_if_req,
  input  logic [ADDR_WIDTH-1:0] i_if_addr,
  input  logic [3:0]            i_if_mask,
  input  logic                  i_if_flush,
  output logic                  o_if_gnt,
  output logic                  o_if_rvalid,
  output logic [XLEN-1:0]       o_if_rdata,
  input  logic                  i_mem_req,
  input  logic                  i_mem_we,
  input  logic [ADDR_WIDTH-1:0] i_mem_addr,
  input  logic [3:0]            i_mem_mask,
  input  logic [XLEN-1:0]       i_mem_wdata,
  output logic                  o_mem_gnt,
  output logic                  o_mem_rvalid,
  output logic [XLEN-1:0]       o_mem_rdata,
  output logic                  o_ram_en,
  output logic                  o_ram_we,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [3:0]            o_ram_mask,
  output logic [XLEN-1:0]       o_ram_wdata,
  input  logic [XLEN-1:0]       i_ram_rdata
);

  logic   w_if_gnt_raw;
  logic   w_mem_gnt_raw;
  logic   w_at_limit;
  logic   w_if_gnt;
  logic   w_mem_gnt;
  owner_e r_owner;

  nnrv_arb_prio u_prio (
    .i_if_req   (i_if_req),
    .i_mem_req  (i_mem_req),
    .i_at_limit (w_at_limit),
    .o_if_gnt   (w_if_gnt_raw),
    .o_mem_gnt  (w_mem_gnt_raw)
  );

  // Reset must kill grants combinationally, even with requests pending.
  assign w_if_gnt  = w_if_gnt_raw & i_rst;
  assign w_mem_gnt = w_mem_gnt_raw & i_rst;

`ifdef NNRV_ARB_STARVE_EN
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_starve_cnt;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_starve_cnt <= '0;
    end else if (!i_if_req || w_if_gnt) begin
      r_starve_cnt <= '0;
    end else if (w_mem_gnt && (r_starve_cnt != LIMIT)) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  assign w_at_limit = (r_starve_cnt == LIMIT);
`else
  logic w_unused_limit;

  assign w_unused_limit = (STARVE_LIMIT != 0);
  assign w_at_limit     = 1'b0;
`endif

  always_comb begin
    o_ram_en    = w_if_gnt | w_mem_gnt;
    o_ram_we    = w_mem_gnt & i_mem_we;
    o_ram_addr  = i_mem_addr;
    o_ram_mask  = i_mem_mask;
    o_ram_wdata = i_mem_wdata;
    if (w_if_gnt) begin
      o_ram_addr = i_if_addr;
      o_ram_mask = i_if_mask;
    end
    if (!i_rst) begin
      o_ram_addr  = '0;
      o_ram_mask  = '0;
      o_ram_wdata = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_owner <= OWN_NONE;
    end else begin
      r_owner <= next_owner(w_if_gnt, i_if_flush, w_mem_gnt, i_mem_we);
    end
  end

  // A flush in the data cycle still suppresses a fetch response already in flight.
  assign o_if_gnt     = w_if_gnt;
  assign o_mem_gnt    = w_mem_gnt;
  assign o_if_rvalid  = (r_owner == OWN_IF) & ~i_if_flush;
  assign o_mem_rvalid = (r_owner == OWN_MEM);
  assign o_if_rdata   = i_rst ? i_ram_rdata : '0;
  assign o_mem_rdata  = i_rst ? i_ram_rdata : '0;

endmodule

// File: doc/nnrv_ram_arb.md
# nnrv_ram_arb

Single-port RAM arbiter for the nnrv core: it shares one synchronous-read, single-port RAM between the instruction-fetch requester and the memory-stage load/store requester. It replaces the dual-read/single-write RAM arrangement. Per cycle it grants at most one requester, drives the RAM command, and returns read data one cycle later tagged to its owner. It sits between nnrv_if / nnrv_mem and the RAM macro. Fetch responses can be flushed on a jump.

## Interface
Parameters:
- ADDR_WIDTH, 8, RAM word address width
- XLEN, 32, data width
- STARVE_LIMIT, 4, consecutive lost cycles after which fetch wins; legal range 1..15

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  asynchronous, active-low reset
- i_if_req  in  1  fetch read request; held until granted
- i_if_addr  in  ADDR_WIDTH  fetch address
- i_if_mask  in  4  fetch byte mask
- i_if_flush  in  1  discard any fetch response due this or next cycle
- o_if_gnt  out  1  fetch command accepted this cycle
- o_if_rvalid  out  1  fetch read data valid
- o_if_rdata  out  XLEN  fetch read data
- i_mem_req  in  1  load/store request; held until granted
- i_mem_we  in  1  1 = store, 0 = load
- i_mem_addr  in  ADDR_WIDTH  load/store address
- i_mem_mask  in  4  byte mask
- i_mem_wdata  in  XLEN  store data
- o_mem_gnt  out  1  load/store accepted this cycle
- o_mem_rvalid  out  1  load data valid
- o_mem_rdata  out  XLEN  load data
- o_ram_en  out  1  RAM access strobe
- o_ram_we  out  1  RAM write enable
- o_ram_addr  out  ADDR_WIDTH  RAM address
- o_ram_mask  out  4  RAM byte mask
- o_ram_wdata  out  XLEN  RAM write data
- i_ram_rdata  in  XLEN  RAM read data, valid the cycle after a read command

## Operation
- Grant logic is combinational from the requests and the registered starvation state.
  - Both requests present: mem wins unless the starvation counter equals STARVE_LIMIT.
  - Single request: it wins.
- RAM command mux:
  - Granted requester drives o_ram_*.
  - o_ram_en = o_if_gnt | o_mem_gnt.
  - o_ram_we = o_mem_gnt & i_mem_we.
  - No grant: o_ram_en = 0, o_ram_we = 0; addr, mask and wdata hold the mem inputs.
- Response tracking, registered:
  - owner_if <= o_if_gnt & ~i_if_flush.
  - owner_mem <= o_mem_gnt & ~i_mem_we.
- Response outputs:
  - o_if_rvalid = owner_if & ~i_if_flush.
  - o_mem_rvalid = owner_mem.
  - Both rdata outputs pass i_ram_rdata through. Their value is don't-care when the matching rvalid is low.
- Stores produce no rvalid. Completion is the grant.
- Flush drops the response and never the RAM command; a flushed fetch still reads the RAM.
- i_rst low forces o_if_gnt, o_mem_gnt, o_ram_en and o_ram_we to 0, regardless of requests.

## Timing
- Reset values: owner_if = 0, owner_mem = 0, starvation counter = 0. All outputs are 0 while i_rst is low.
- Latency:
  - Grant is in the same cycle as the request.
  - Read data arrives exactly 1 cycle after the grant.
  - Throughput is 1 access per cycle.
- Back-to-back grants to different owners are legal. rvalid follows each grant in order, one cycle behind.
- Starvation counter (4 bits):
  - Increments when i_if_req & o_mem_gnt.
  - Clears when o_if_gnt, or when i_if_req = 0.
  - Saturates at STARVE_LIMIT.
- Simultaneous flush and rvalid: rvalid is suppressed.
- Flush in the grant cycle: the next cycle carries no fetch rvalid.
- Reset asserted mid-access: the pending rvalid is lost and no response is emitted after release.
- Requester protocol: req, addr, mask and wdata are held stable until gnt. Dropping req before gnt is allowed (cancel).

## Configuration
- NNRV_ARB_STARVE_EN defined: starvation counter and STARVE_LIMIT override are active, as above.
- Undefined: strict mem-over-fetch priority. The counter is not built and the STARVE_LIMIT parameter is ignored.

## Structure
- Shared package nnrv_pkg holds:
  - the owner encoding (OWN_NONE, OWN_IF, OWN_MEM);
  - the default XLEN and ADDR_WIDTH constants.
- One sub-module, nnrv_arb_prio: the combinational two-way priority picker with starvation override. It takes both reqs plus the counter-at-limit flag and outputs the two one-hot grants.
- Flops, flush handling and the RAM mux stay in nnrv_ram_arb.

## Test plan
- Fetch only:
  - Stimulus: if_req with addr 0x10; RAM holds 0xDEADBEEF at 0x10.
  - Response: if_gnt in cycle 0; if_rvalid with rdata 0xDEADBEEF in cycle 1; mem_rvalid stays 0.
- Conflict:
  - Stimulus: if_req and mem_req (load, addr 0x20) in the same cycle.
  - Response: mem_gnt = 1, if_gnt = 0; ram_addr = 0x20; if_gnt follows next cycle; rvalids arrive in order mem then if.
- Store then load:
  - Stimulus: mem store, wdata 0x12345678, mask 0xF, addr 0x04; then load 0x04.
  - Response: the store produces no rvalid; the load returns 0x12345678 two cycles after the store's grant.
- Starvation (macro defined, STARVE_LIMIT = 4):
  - Stimulus: continuous mem_req and if_req.
  - Response: mem is granted 4 cycles; fetch is granted in the 5th; the pattern repeats.
  - With the macro undefined, fetch is never granted.
- Flush:
  - Stimulus: if_gnt in cycle 0, i_if_flush = 1 in cycle 1.
  - Response: if_rvalid = 0 in cycle 1; a mem load granted in cycle 1 still returns mem_rvalid in cycle 2.
- Reset mid-access:
  - Stimulus: i_rst driven low asynchronously between a load grant and its data.
  - Response: mem_rvalid = 0 immediately and all grants 0; after release with no req, no rvalid appears.
